// File: rtl/wf68k30l_dr_writeback.sv
// Data-register writeback sequencer: queues execution results and replays each into the register
// file as MARK -> WRITE -> UNMARK. Define WF68K30L_DRWB_SCAN_EN for full-depth queueing and PEND_HIT.
`timescale 1ns/1ps
module wf68k30l_dr_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FLUSH,
  input  logic                     RES_VALID,
  output logic                     RES_READY,
  input  logic [2:0]               RES_REG1,
  input  logic [2:0]               RES_REG2,
  input  logic                     RES_PAIR,
  input  logic [1:0]               RES_SIZE,
  input  logic [31:0]              RES_DATA1,
  input  logic [31:0]              RES_DATA2,
  output logic [2:0]               DR_SEL_WR_1,
  output logic [2:0]               DR_SEL_WR_2,
  output logic                     DR_MARK_USED,
  output logic                     USE_DPAIR,
  output logic                     DR_WR_1,
  output logic                     DR_WR_2,
  output logic [31:0]              DR_IN_1,
  output logic [31:0]              DR_IN_2,
  output logic [1:0]               OP_SIZE,
  output logic                     UNMARK,
  input  logic [2:0]               RD_SEL_1,
  input  logic [2:0]               RD_SEL_2,
  output logic                     PEND_HIT,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     BUSY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {SZ_LONG = 2'b00, SZ_WORD = 2'b01, SZ_BYTE = 2'b10} size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_WRITE, ST_UNMARK} state_e;

  typedef struct packed {
    logic [2:0]  reg1;
    logic [2:0]  reg2;
    logic        pair;
    logic [1:0]  size;
    logic [31:0] data1;
    logic [31:0] data2;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  entry_t        head;
  logic          push;
  logic          size_ok;

  assign head = mem_q[rd_q];

`ifdef WF68K30L_DRWB_SCAN_EN
  assign RES_READY = !RESET && !FLUSH && (count_q < CW'(DEPTH));
`else
  assign RES_READY = !RESET && !FLUSH && (count_q == '0) && (state_q == ST_IDLE);
`endif

  assign push = RES_VALID && RES_READY;

  // COUNT includes the head until its UNMARK; a flush drops it from COUNT but lets UNMARK
  // finish, so wr is parked one past the head and the UNMARK pop lands rd on it.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (FLUSH) begin
          count_d = '0;
          wr_d    = rd_q;
        end else begin
          count_d = count_q + CW'(push);
          if (count_q != '0) state_d = ST_MARK;
        end
      end
      ST_MARK, ST_WRITE: begin
        if (FLUSH) begin
          count_d = '0;
          wr_d    = rd_q + 1'b1;
          state_d = ST_UNMARK;
        end else begin
          count_d = count_q + CW'(push);
          state_d = (state_q == ST_MARK) ? ST_WRITE : ST_UNMARK;
        end
      end
      ST_UNMARK: begin
        rd_d = rd_q + 1'b1;
        if (FLUSH) begin
          count_d = '0;
          wr_d    = rd_q + 1'b1;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q + CW'(push) - CW'(count_q != '0);
          state_d = (count_q > CW'(1)) ? ST_MARK : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wr_q] <= '{reg1: RES_REG1, reg2: RES_REG2, pair: RES_PAIR, size: RES_SIZE,
                         data1: RES_DATA1, data2: RES_DATA2};
      end
    end
  end

  assign size_ok = head.size inside {SZ_LONG, SZ_WORD, SZ_BYTE};

  always_comb begin
    DR_SEL_WR_1  = '0;
    DR_SEL_WR_2  = '0;
    DR_IN_1      = '0;
    DR_IN_2      = '0;
    OP_SIZE      = '0;
    if (state_q != ST_IDLE) begin
      DR_SEL_WR_1 = head.reg1;
      DR_SEL_WR_2 = head.reg2;
      DR_IN_1     = head.data1;
      DR_IN_2     = head.data2;
      OP_SIZE     = head.size;
    end
    DR_MARK_USED = (state_q == ST_MARK);
    USE_DPAIR    = (state_q == ST_MARK) && head.pair;
    // a pair aimed at one register keeps only DATA2
    DR_WR_1      = (state_q == ST_WRITE) && size_ok && !(head.pair && head.reg1 == head.reg2);
    DR_WR_2      = (state_q == ST_WRITE) && size_ok && head.pair;
    UNMARK       = (state_q == ST_UNMARK);
  end

`ifdef WF68K30L_DRWB_SCAN_EN
  // in IDLE the head has not been marked yet, so it is still a pending entry
  always_comb begin
    PEND_HIT = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_t e;
      logic   queued;
      e      = mem_q[rd_q + PW'(i)];
      queued = (32'(count_q) > i) && ((state_q == ST_IDLE) || (i != 0));
      if (queued && ((e.reg1 == RD_SEL_1) || (e.reg1 == RD_SEL_2) ||
                     (e.pair && ((e.reg2 == RD_SEL_1) || (e.reg2 == RD_SEL_2))))) begin
        PEND_HIT = 1'b1;
      end
    end
  end
`else
  logic unused_rd_sel;
  assign unused_rd_sel = ^{RD_SEL_1, RD_SEL_2};
  assign PEND_HIT      = 1'b0;
`endif

  assign COUNT = count_q;
  assign BUSY  = (count_q != '0) || (state_q != ST_IDLE);

endmodule
